// File: rtl/carry_chain_pkg.sv
// Shared helpers for the fabric carry-chain blocks: segment sizing, the
// WIDTH/STAGES legality check and the MUXCY carry primitive.
package carry_chain_pkg;

    function automatic int seg_bits(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit chain_params_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // MUXCY: propagate the incoming carry when s is set, otherwise take di.
    function automatic logic muxcy(input logic ci, input logic di, input logic s);
        return s ? ci : di;
    endfunction

endpackage

// File: rtl/carry_seg.sv
// Purely combinational SEG-bit MUXCY/XORCY chain; registers live in the parent.
module carry_seg
    import carry_chain_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic           ci,
    input  logic [SEG-1:0] di,
    input  logic [SEG-1:0] s,
    output logic [SEG-1:0] o,
    output logic [SEG-1:0] lo,
    output logic           co
);

    always_comb begin
        logic c;
        c  = ci;
        o  = '0;
        lo = '0;
        for (int i = 0; i < SEG; i++) begin
            o[i]  = s[i] ^ c;
            c     = muxcy(c, di[i], s[i]);
            lo[i] = c;
        end
        co = c;
    end

endmodule

// File: rtl/carry_chain_pipe.sv
// Pipelined MUXCY/XORCY carry chain cut into STAGES equal segments.
// Optional per-bit carry tap output LO enabled by CARRY_CHAIN_PIPE_LO_TAP_EN.
module carry_chain_pipe
    import carry_chain_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             VALID_IN,
    input  logic             CI,
    input  logic [WIDTH-1:0] DI,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] O,
    output logic             CO,
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
    output logic [WIDTH-1:0] LO,
`endif
    output logic             VALID_OUT
);

    localparam int SEG = seg_bits(WIDTH, STAGES);

    if (!chain_params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("carry_chain_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    logic [STAGES-1:0] seg_co;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] valid_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        logic [SEG-1:0] seg_di;
        logic [SEG-1:0] seg_s;
        logic [SEG-1:0] seg_o;
        logic [SEG-1:0] seg_lo;
        logic           seg_ci;
        logic           seg_cout;
        logic           carry_d;
        logic           carry_q;
        logic [SEG-1:0] o_pipe_d [STAGES-k];
        logic [SEG-1:0] o_pipe_q [STAGES-k];

        if (k == 0) begin : g_direct
            assign seg_di = DI[SEG-1:0];
            assign seg_s  = S[SEG-1:0];
            assign seg_ci = CI;
        end else begin : g_skew
            // Delay this segment's operands k cycles so they meet the carry from segment k-1.
            logic [SEG-1:0] di_skew_d [k];
            logic [SEG-1:0] di_skew_q [k];
            logic [SEG-1:0] s_skew_d  [k];
            logic [SEG-1:0] s_skew_q  [k];

            always_comb begin
                di_skew_d = di_skew_q;
                s_skew_d  = s_skew_q;
                if (CE) begin
                    di_skew_d[0] = DI[k*SEG +: SEG];
                    s_skew_d[0]  = S[k*SEG +: SEG];
                    for (int j = 1; j < k; j++) begin
                        di_skew_d[j] = di_skew_q[j-1];
                        s_skew_d[j]  = s_skew_q[j-1];
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    di_skew_q <= '{default: '0};
                    s_skew_q  <= '{default: '0};
                end else begin
                    di_skew_q <= di_skew_d;
                    s_skew_q  <= s_skew_d;
                end
            end

            assign seg_di = di_skew_q[k-1];
            assign seg_s  = s_skew_q[k-1];
            assign seg_ci = seg_co[k-1];
        end

        carry_seg #(.SEG(SEG)) u_seg (
            .ci (seg_ci),
            .di (seg_di),
            .s  (seg_s),
            .o  (seg_o),
            .lo (seg_lo),
            .co (seg_cout)
        );

        always_comb begin
            carry_d  = CE ? seg_cout : carry_q;
            o_pipe_d = o_pipe_q;
            if (CE) begin
                o_pipe_d[0] = seg_o;
                for (int j = 1; j < STAGES - k; j++) begin
                    o_pipe_d[j] = o_pipe_q[j-1];
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                carry_q  <= 1'b0;
                o_pipe_q <= '{default: '0};
            end else begin
                carry_q  <= carry_d;
                o_pipe_q <= o_pipe_d;
            end
        end

        assign seg_co[k]          = carry_q;
        assign O[k*SEG +: SEG]    = o_pipe_q[STAGES-k-1];

`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
        logic [SEG-1:0] lo_pipe_d [STAGES-k];
        logic [SEG-1:0] lo_pipe_q [STAGES-k];

        always_comb begin
            lo_pipe_d = lo_pipe_q;
            if (CE) begin
                lo_pipe_d[0] = seg_lo;
                for (int j = 1; j < STAGES - k; j++) begin
                    lo_pipe_d[j] = lo_pipe_q[j-1];
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                lo_pipe_q <= '{default: '0};
            end else begin
                lo_pipe_q <= lo_pipe_d;
            end
        end

        assign LO[k*SEG +: SEG] = lo_pipe_q[STAGES-k-1];
`else
        logic unused_lo;
        assign unused_lo = ^seg_lo;
`endif
    end

    always_comb begin
        valid_d = valid_q;
        if (CE) begin
            valid_d[0] = VALID_IN;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign CO        = seg_co[STAGES-1];
    assign VALID_OUT = valid_q[STAGES-1];

endmodule

// File: tb/tb_carry_chain_pipe.sv
// Self-checking bench for carry_chain_pipe using the adder mapping S=A^B, DI=A,
// with scoreboards for an 8-bit/2-stage instance and 16-bit 1- and 4-stage instances.
module tb_carry_chain_pipe;

    typedef struct packed {
        logic [15:0] o;
        logic        co;
        logic [15:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        edge_ce;
    logic        edge_rst_n;

    logic        vin8, ci8, co8, vout8;
    logic [7:0]  di8, s8, o8;
    logic        vin16, ci16;
    logic [15:0] di16, s16;
    logic [15:0] o_s1, o_s4;
    logic        co_s1, co_s4, vout_s1, vout_s4;
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
    logic [7:0]  lo8;
    logic [15:0] lo_s1, lo_s4;
`endif

    exp_t exp8_q[$];
    exp_t exp_s1_q[$];
    exp_t exp_s4_q[$];

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    carry_chain_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .VALID_IN(vin8), .CI(ci8),
        .DI(di8), .S(s8), .O(o8), .CO(co8),
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
        .LO(lo8),
`endif
        .VALID_OUT(vout8)
    );

    carry_chain_pipe #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .VALID_IN(vin16), .CI(ci16),
        .DI(di16), .S(s16), .O(o_s1), .CO(co_s1),
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
        .LO(lo_s1),
`endif
        .VALID_OUT(vout_s1)
    );

    carry_chain_pipe #(.WIDTH(16), .STAGES(4)) dut_s4 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .VALID_IN(vin16), .CI(ci16),
        .DI(di16), .S(s16), .O(o_s4), .CO(co_s4),
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
        .LO(lo_s4),
`endif
        .VALID_OUT(vout_s4)
    );

    // Reference adder: LO[i] is the carry into bit i+1, recovered from the sum bits.
    function automatic exp_t addModel(input logic [15:0] a, input logic [15:0] b,
                                      input logic c, input int w);
        exp_t        e;
        logic [16:0] full;
        logic [16:0] mask;
        full = {1'b0, a} + {1'b0, b} + {16'd0, c};
        mask = (17'd1 << w) - 17'd1;
        e.co = full[w];
        e.o  = full[15:0] & mask[15:0];
        e.lo = '0;
        for (int i = 0; i < w - 1; i++) begin
            e.lo[i] = full[i+1] ^ a[i+1] ^ b[i+1];
        end
        e.lo[w-1] = e.co;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            nPass++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        vin8 = 1'b1;
        di8  = a;
        s8   = a ^ b;
        ci8  = c;
        if (ce && rst_n) exp8_q.push_back(addModel({8'd0, a}, {8'd0, b}, c, 8));
        tick();
        vin8 = 1'b0;
    endtask

    always @(posedge clk) begin
        edge_ce    = ce;
        edge_rst_n = rst_n;
    end

    // Compare each freshly produced result against the head of its scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (edge_ce === 1'b1 && edge_rst_n === 1'b1) begin
            if (vout8) begin
                if (exp8_q.size() == 0) checkOutput("spurious8", 32'(vout8), 32'd0);
                else begin
                    e = exp8_q.pop_front();
                    checkOutput("o8", 32'(o8), 32'(e.o[7:0]));
                    checkOutput("co8", 32'(co8), 32'(e.co));
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
                    checkOutput("lo8", 32'(lo8), 32'(e.lo[7:0]));
`endif
                end
            end
            if (vout_s1) begin
                if (exp_s1_q.size() == 0) checkOutput("spurious_s1", 32'(vout_s1), 32'd0);
                else begin
                    e = exp_s1_q.pop_front();
                    checkOutput("o_s1", 32'(o_s1), 32'(e.o));
                    checkOutput("co_s1", 32'(co_s1), 32'(e.co));
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
                    checkOutput("lo_s1", 32'(lo_s1), 32'(e.lo));
`endif
                end
            end
            if (vout_s4) begin
                if (exp_s4_q.size() == 0) checkOutput("spurious_s4", 32'(vout_s4), 32'd0);
                else begin
                    e = exp_s4_q.pop_front();
                    checkOutput("o_s4", 32'(o_s4), 32'(e.o));
                    checkOutput("co_s4", 32'(co_s4), 32'(e.co));
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
                    checkOutput("lo_s4", 32'(lo_s4), 32'(e.lo));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d, passed %0d", nChecks, nPass);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic        c;

        rst_n = 1'b0; ce = 1'b1;
        vin8 = 1'b0; ci8 = 1'b0; di8 = '0; s8 = '0;
        vin16 = 1'b0; ci16 = 1'b0; di16 = '0; s16 = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        checkOutput("rst_o", 32'(o8), 32'd0);
        checkOutput("rst_co", 32'(co8), 32'd0);
        checkOutput("rst_valid", 32'(vout8), 32'd0);
        checkOutput("rst_valid_s4", 32'(vout_s4), 32'd0);

        $display("[TB] basic add and latency");
        applyStimulus(8'h7F, 8'h01, 1'b0);
        checkOutput("basic_early", 32'(vout8), 32'd0);
        tick();
        checkOutput("basic_valid", 32'(vout8), 32'd1);
        tick();
        checkOutput("basic_once", 32'(vout8), 32'd0);

        $display("[TB] carry across boundary");
        applyStimulus(8'hFF, 8'h01, 1'b0);
        tick();
        checkOutput("boundary_valid", 32'(vout8), 32'd1);
        tick();

        $display("[TB] streaming");
        applyStimulus(8'h01, 8'h01, 1'b0);
        applyStimulus(8'h0F, 8'h01, 1'b0);
        applyStimulus(8'hF0, 8'h10, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        checkOutput("stream_valid_3", 32'(vout8), 32'd1);
        tick();
        checkOutput("stream_valid_4", 32'(vout8), 32'd1);
        tick();
        checkOutput("stream_done", 32'(vout8), 32'd0);

        $display("[TB] stall");
        applyStimulus(8'h01, 8'h01, 1'b0);
        applyStimulus(8'h0F, 8'h01, 1'b0);
        ce = 1'b0; vin8 = 1'b1; di8 = 8'hA5; s8 = 8'h3C; ci8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_valid", 32'(vout8), 32'd1);
            checkOutput("stall_o", 32'(o8), 32'h02);
        end
        ce = 1'b1; vin8 = 1'b0;
        tick();
        checkOutput("stall_resume", 32'(vout8), 32'd1);
        tick();
        checkOutput("stall_done", 32'(vout8), 32'd0);

        $display("[TB] reset mid-flight");
        applyStimulus(8'h55, 8'h22, 1'b0);
        vin8 = 1'b1; di8 = 8'h33; s8 = 8'h44; ci8 = 1'b1;
        rst_n = 1'b0; ce = 1'b0;
        exp8_q.delete();
        tick();
        rst_n = 1'b1; ce = 1'b1; vin8 = 1'b0;
        checkOutput("midrst_o", 32'(o8), 32'd0);
        checkOutput("midrst_co", 32'(co8), 32'd0);
        checkOutput("midrst_valid", 32'(vout8), 32'd0);
`ifdef CARRY_CHAIN_PIPE_LO_TAP_EN
        checkOutput("midrst_lo", 32'(lo8), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("midrst_quiet", 32'(vout8), 32'd0);
        end

        $display("[TB] random sweep STAGES=1 and STAGES=4");
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom_range(0, 1));
            if (n == 0) begin a = 16'hFFFF; b = 16'h0001; c = 1'b0; end
            ce    = ($urandom_range(0, 3) != 0);
            vin16 = 1'b1;
            di16  = a;
            s16   = a ^ b;
            ci16  = c;
            if (ce) begin
                exp_s1_q.push_back(addModel(a, b, c, 16));
                exp_s4_q.push_back(addModel(a, b, c, 16));
            end
            tick();
        end
        vin16 = 1'b0; ce = 1'b1;
        repeat (8) tick();

        checkOutput("drain8", 32'(exp8_q.size()), 32'd0);
        checkOutput("drain_s1", 32'(exp_s1_q.size()), 32'd0);
        checkOutput("drain_s4", 32'(exp_s4_q.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
